// File: rtl/sr_flag_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_flag_sequencer_pkg
// Purpose  : Shared state/op encodings and helpers for the SR flag sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sr_flag_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DONE    = 3'd3,
    ST_CLR     = 3'd4,
    ST_CLRHOLD = 3'd5
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // (v + 1) mod n without a divider
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_flag_sequencer_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin picker; search starts at ptr, wraps up.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);

  int            w_cand;
  logic [IW-1:0] w_cand_idx;
  logic          w_found;

  always_comb begin
    win        = '0;
    win_idx    = '0;
    w_found    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = int'(ptr) + i;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      w_cand_idx = IW'(w_cand);
      if (!w_found && req[w_cand_idx]) begin
        w_found         = 1'b1;
        win[w_cand_idx] = 1'b1;
        win_idx         = w_cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sr_flag_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sr_flag_sequencer
// Purpose  : Serialises set/clear requests onto an SR latch bank, never S&R.
// Revision : 1.0 - initial release
// ============================================================================
module sr_flag_sequencer
  import sr_flag_sequencer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAG-1:0]     s_vec,
  output logic [NFLAG-1:0]     r_vec,
  output logic [NFLAG-1:0]     q_shadow,
  output logic                 busy
);

  localparam int c_PTRW = $clog2(NREQ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_PTRW-1:0]   r_ptr;
  logic [c_PTRW-1:0]   r_win;
  logic [NREQ-1:0]     r_win_oh;
  logic                r_op;
  logic [IDXW-1:0]     r_idx;
  logic                r_clr_pend;
  logic [NFLAG-1:0]    r_q;

  logic [NREQ-1:0]     w_win_oh;
  logic [c_PTRW-1:0]   w_win_idx;
  logic [IDXW-1:0]     w_idx_sel;
  logic                w_op_sel;
  logic                w_redundant;
  logic                w_take;

  rr_picker #(
    .N  (NREQ),
    .IW (c_PTRW)
  ) u_picker (
    .req     (req),
    .ptr     (r_ptr),
    .win     (w_win_oh),
    .win_idx (w_win_idx)
  );

  assign w_idx_sel = idx[w_win_idx*IDXW +: IDXW];
  assign w_op_sel  = op[w_win_idx];
  // Out-of-range targets have no latch to drive, so they complete as no-ops
  assign w_redundant = (int'(w_idx_sel) >= NFLAG) || (r_q[w_idx_sel] == w_op_sel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_clr_pend || clr_all) begin
          w_state_nxt = ST_CLR;
        end else if (|req) begin
          w_take      = 1'b1;
          w_state_nxt = w_redundant ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE:   w_state_nxt = ST_HOLD;
      ST_HOLD:    w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      ST_CLR:     w_state_nxt = ST_CLRHOLD;
      ST_CLRHOLD: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Drives decode straight from state so an async reset drops them at once
  always_comb begin
    gnt   = '0;
    s_vec = '0;
    r_vec = '0;
    case (r_state)
      ST_DRIVE: begin
        if (r_op == OP_SET) begin
          s_vec[r_idx] = 1'b1;
        end else begin
          r_vec[r_idx] = 1'b1;
        end
      end
      ST_DONE: gnt   = r_win_oh;
      ST_CLR:  r_vec = '1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_win      <= '0;
      r_win_oh   <= '0;
      r_op       <= OP_CLR;
      r_idx      <= '0;
      r_clr_pend <= 1'b0;
      r_q        <= '0;
    end else begin
      // A pulse landing in CLR itself is kept, so it triggers a further clear
      if (r_state == ST_CLR) begin
        r_clr_pend <= clr_all;
      end else begin
        r_clr_pend <= r_clr_pend | clr_all;
      end
      if (w_take) begin
        r_win    <= w_win_idx;
        r_win_oh <= w_win_oh;
        r_op     <= w_op_sel;
        r_idx    <= w_idx_sel;
      end
      if (r_state == ST_DRIVE) begin
        r_q[r_idx] <= r_op;
      end
      if (r_state == ST_CLR) begin
        r_q <= '0;
      end
      if (r_state == ST_DONE) begin
        r_ptr <= c_PTRW'(wrap_inc(int'(r_win), NREQ));
      end
    end
  end

  assign q_shadow = r_q;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
